// File: rtl/seq_div_pkg.sv
// Shared FSM encoding and sizing helper for the sequential restoring divider.
// The optional two's-complement mode is selected by SEQ_DIV_SIGNED_EN.
package seq_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Step counter must be able to represent 0..WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, and keep the trial result when no borrow occurs.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   i_prem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_prem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_trial;

  assign w_shift = {i_prem, i_bit};
  // Partial remainder is always below the divisor, so w_shift's top bit is 0
  // and bit WIDTH+1 of the difference is a clean borrow flag.
  assign w_trial = w_shift - {2'b00, i_divisor};
  assign o_qbit  = ~w_trial[WIDTH+1];
  assign o_prem  = o_qbit ? w_trial[WIDTH:0] : w_shift[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (magnitude core plus sign fix-up).
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH:0]   r_prem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;
  logic             r_dz_out;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [WIDTH:0]   w_prem;
  logic             w_qbit;
  logic             w_last;
  logic [WIDTH-1:0] w_quo_raw;
  logic [WIDTH-1:0] w_rem_raw;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_quo_fin;
  logic [WIDTH-1:0] w_rem_fin;
  logic [WIDTH-1:0] w_dvd_org;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_prem    (r_prem),
    .i_bit     (r_dvd[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_prem    (w_prem),
    .o_qbit    (w_qbit)
  );

  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_quo_raw = {r_quo[WIDTH-2:0], w_qbit};
  assign w_rem_raw = w_prem[WIDTH-1:0];

`ifdef SEQ_DIV_SIGNED_EN
  logic r_neg_dvd;
  logic r_neg_dvs;

  assign w_dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  // -MIN/-1 yields magnitude 2^(WIDTH-1) with a positive sign, which wraps to MIN.
  assign w_quo_fin = (r_neg_dvd ^ r_neg_dvs) ? -w_quo_raw : w_quo_raw;
  assign w_rem_fin = r_neg_dvd ? -w_rem_raw : w_rem_raw;
  assign w_dvd_org = r_neg_dvd ? -r_dvd : r_dvd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_dvd <= 1'b0;
      r_neg_dvs <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_neg_dvd <= dividend[WIDTH-1];
      r_neg_dvs <= divisor[WIDTH-1];
    end
  end
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_quo_fin = w_quo_raw;
  assign w_rem_fin = w_rem_raw;
  assign w_dvd_org = r_dvd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // A zero divisor spends a single cycle in CALC so done lands one edge after accept.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_CALC;
      ST_CALC: if (r_dz || w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_quo       <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      r_dz        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dz_out    <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_dvd    <= w_dvd_mag;
            r_dvs    <= w_dvs_mag;
            r_quo    <= '0;
            r_prem   <= '0;
            r_cnt    <= '0;
            r_dz     <= (divisor == '0);
            r_busy   <= 1'b1;
            r_dz_out <= 1'b0;
          end
        end
        ST_CALC: begin
          if (r_dz) begin
            r_quotient  <= '1;
            r_remainder <= w_dvd_org;
            r_dz_out    <= 1'b1;
            r_done      <= 1'b1;
          end else begin
            r_prem <= w_prem;
            r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
            r_quo  <= w_quo_raw;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_quotient  <= w_quo_fin;
              r_remainder <= w_rem_fin;
              r_done      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dz_out;

endmodule
